// File: rtl/frac_lut_pkg.sv
// Shared definitions for the fracturable LUT with configuration chain.
//   MIN_K_DEF     : default smallest fractured LUT size
//   cfg_len()     : chain length for a K-input LUT (truth table + mode bits)
//   mode_width()  : storage width for the mode bits (at least 1 so K==MIN_K elaborates)
//   cnt_width()   : load-counter width, able to hold CFG_LEN+1
//   state_t       : configuration-load FSM states
package frac_lut_pkg;

  localparam int MIN_K_DEF = 4;

  function automatic int cfg_len(input int k, input int min_k);
    return (1 << k) + (k - min_k);
  endfunction

  function automatic int mode_width(input int k, input int min_k);
    return (k > min_k) ? (k - min_k) : 1;
  endfunction

  function automatic int cnt_width(input int k, input int min_k);
    return $clog2(cfg_len(k, min_k) + 2);
  endfunction

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CFG   = 2'd2
  } state_t;

endpackage

// File: rtl/frac_lut_tree.sv
// Purely combinational LUT read tree.
//   tt           : truth table, tt[i] is the output for address i
//   mode         : fracture mode bits; mode[j] forces address bit MIN_K+j high
//   in           : LUT inputs, in[0] is the address LSB
//   lut_full_out : K-input function of the effective address
//   lut_hi_out   : two (K-1)-input functions (top / bottom halves of tt)
//   lut_lo_out   : 2^(K-MIN_K) MIN_K-input functions, addressed by raw in[MIN_K-1:0]
module frac_lut_tree
  import frac_lut_pkg::*;
#(
  parameter int K     = 6,
  parameter int MIN_K = MIN_K_DEF
) (
  input  logic [2**K-1:0]                 tt,
  input  logic [mode_width(K, MIN_K)-1:0] mode,
  input  logic [K-1:0]                    in,
  output logic [2**(K-MIN_K)-1:0]         lut_lo_out,
  output logic [1:0]                      lut_hi_out,
  output logic                            lut_full_out
);

  localparam int NLO = 2**(K-MIN_K);

  logic [K-1:0] e;

  for (genvar i = 0; i < K; i++) begin : g_eff
    if (i < MIN_K) begin : g_pass
      assign e[i] = in[i];
    end else begin : g_mode
      assign e[i] = in[i] | mode[i-MIN_K];
    end
  end

  assign lut_full_out = tt[e];

  // Each half-LUT reads its own half of tt with the top address bit replaced.
  for (genvar h = 0; h < 2; h++) begin : g_hi
    logic [K-1:0] idx;
    assign idx = (K'(h) << (K-1)) | {1'b0, e[K-2:0]};
    assign lut_hi_out[h] = tt[idx];
  end

  // Lo outputs ignore the mode bits: each one owns a fixed 2^MIN_K slice of tt.
  for (genvar l = 0; l < NLO; l++) begin : g_lo
    logic [K-1:0] idx;
    assign idx = (K'(l) << MIN_K) | K'(in[MIN_K-1:0]);
    assign lut_lo_out[l] = tt[idx];
  end

endmodule

// File: rtl/frac_lut_k_cfg.sv
// K-input fracturable LUT with serial configuration chain and load FSM.
//   clk, reset    : clock, synchronous active-high reset
//   cfg_en        : shift-enable for the configuration chain
//   ccff_head     : serial configuration in (host sends cfg[CFG_LEN-1] first)
//   ccff_tail     : last chain bit, used for daisy-chaining and readback
//   in            : LUT inputs
//   ff_en         : output-register enable (REG_OUT=1 only)
//   lut_lo_out    : MIN_K-input fractured outputs
//   lut_hi_out    : (K-1)-input fractured outputs
//   lut_full_out  : K-input output
//   cfg_done      : configuration is valid
//   cfg_err       : last load burst had the wrong length (sticky until next load)
//
// state    | meaning
// ST_UNCFG | no valid configuration; LUT outputs forced to 0
// ST_LOAD  | shift burst in progress; counting shifted bits
// ST_CFG   | last burst was exactly CFG_LEN bits; LUT live
module frac_lut_k_cfg
  import frac_lut_pkg::*;
#(
  parameter int K       = 6,
  parameter int MIN_K   = MIN_K_DEF,
  parameter int REG_OUT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_en,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic [K-1:0]            in,
  input  logic                    ff_en,
  output logic [2**(K-MIN_K)-1:0] lut_lo_out,
  output logic [1:0]              lut_hi_out,
  output logic                    lut_full_out,
  output logic                    cfg_done,
  output logic                    cfg_err
);

  localparam int CFG_LEN = cfg_len(K, MIN_K);
  localparam int NTT     = 2**K;
  localparam int NLO     = 2**(K-MIN_K);
  localparam int MW      = mode_width(K, MIN_K);
  localparam int CW      = cnt_width(K, MIN_K);

  localparam logic [CW-1:0] LEN_C   = CW'(CFG_LEN);
  localparam logic [CW-1:0] LEN_MAX = CW'(CFG_LEN + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_d;
  logic [CFG_LEN-1:0] cfg;
  logic [MW-1:0]     mode;
  logic [NLO-1:0]    t_lo;
  logic [1:0]        t_hi;
  logic              t_full;
  logic              gate_d;

  // Chain: cfg[0] takes the head, the top bit is the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (cfg_en) begin
      cfg <= {cfg[CFG_LEN-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CFG_LEN-1];

  if (K > MIN_K) begin : g_mode
    assign mode = cfg[CFG_LEN-1:NTT];
  end else begin : g_nomode
    assign mode = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_UNCFG;
      cnt_q    <= '0;
      cfg_err  <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_err  <= err_d;
      cfg_done <= (state_d == ST_CFG);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = cfg_err;
    case (state_q)
      ST_UNCFG, ST_CFG: begin
        if (cfg_en) begin
          // This cycle's shift is the first bit of the new burst.
          state_d = ST_LOAD;
          cnt_d   = CW'(1);
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cfg_en) begin
          // Saturate so over-long bursts can never wrap back to CFG_LEN.
          if (cnt_q != LEN_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q == LEN_C) begin
          state_d = ST_CFG;
        end else begin
          state_d = ST_UNCFG;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNCFG;
      end
    endcase
  end

  frac_lut_tree #(
    .K     (K),
    .MIN_K (MIN_K)
  ) u_tree (
    .tt           (cfg[NTT-1:0]),
    .mode         (mode),
    .in           (in),
    .lut_lo_out   (t_lo),
    .lut_hi_out   (t_hi),
    .lut_full_out (t_full)
  );

  // Gating follows the next state so registered outputs clear on the same
  // edge that cfg_done drops, and can load on the edge that it rises.
  assign gate_d = (state_d != ST_CFG);

  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset || gate_d) begin
        lut_lo_out   <= '0;
        lut_hi_out   <= '0;
        lut_full_out <= 1'b0;
      end else if (ff_en) begin
        lut_lo_out   <= t_lo;
        lut_hi_out   <= t_hi;
        lut_full_out <= t_full;
      end
    end
  end else begin : g_comb
    assign lut_lo_out   = cfg_done ? t_lo   : '0;
    assign lut_hi_out   = cfg_done ? t_hi   : '0;
    assign lut_full_out = cfg_done ? t_full : 1'b0;
  end

endmodule

// File: tb/tb_frac_lut_k_cfg.sv
// Self-checking bench for frac_lut_k_cfg (K=6, MIN_K=4, REG_OUT=1).
// A behavioural model tracks the chain as a bit array, burst lengths as a
// plain integer and computes LUT outputs by direct table indexing.
module tb_frac_lut_k_cfg;

  localparam int K       = 6;
  localparam int MIN_K   = 4;
  localparam int CFG_LEN = 66;
  localparam int NTT     = 64;
  localparam int NLO     = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_en;
  logic           ccff_head;
  logic           ccff_tail;
  logic [K-1:0]   in_v;
  logic           ff_en;
  logic [NLO-1:0] lut_lo_out;
  logic [1:0]     lut_hi_out;
  logic           lut_full_out;
  logic           cfg_done;
  logic           cfg_err;

  always #5 clk = ~clk;

  frac_lut_k_cfg #(
    .K       (K),
    .MIN_K   (MIN_K),
    .REG_OUT (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_en       (cfg_en),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .in           (in_v),
    .ff_en        (ff_en),
    .lut_lo_out   (lut_lo_out),
    .lut_hi_out   (lut_hi_out),
    .lut_full_out (lut_full_out),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  bit             m_chain [CFG_LEN];
  bit             m_loading;
  bit             m_valid;
  bit             m_err;
  int             m_burst;
  logic           m_full;
  logic [1:0]     m_hi;
  logic [NLO-1:0] m_lo;

  function automatic int mode_val();
    return int'(m_chain[NTT]) + 2 * int'(m_chain[NTT+1]);
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic head,
                            input logic [K-1:0] inx, input logic ffe);
    int ix;
    int eff;
    ix = int'(inx);
    if (rst) begin
      foreach (m_chain[i]) m_chain[i] = 1'b0;
      m_loading = 1'b0;
      m_valid   = 1'b0;
      m_err     = 1'b0;
      m_burst   = 0;
      m_full    = 1'b0;
      m_hi      = '0;
      m_lo      = '0;
    end else begin
      if (en) begin
        if (!m_loading) begin
          m_loading = 1'b1;
          m_burst   = 0;
          m_err     = 1'b0;
        end
        m_burst++;
        m_valid = 1'b0;
        for (int i = CFG_LEN - 1; i > 0; i--) m_chain[i] = m_chain[i-1];
        m_chain[0] = head;
      end else if (m_loading) begin
        m_loading = 1'b0;
        if (m_burst == CFG_LEN) m_valid = 1'b1;
        else m_err = 1'b1;
      end
      if (!m_valid) begin
        m_full = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
      end else if (ffe) begin
        eff    = ix | (mode_val() << MIN_K);
        m_full = m_chain[eff];
        for (int h = 0; h < 2; h++) m_hi[h] = m_chain[h * 32 + (eff % 32)];
        for (int l = 0; l < NLO; l++) m_lo[l] = m_chain[l * 16 + (ix % 16)];
      end
    end
  endtask

  task automatic check_all();
    check("tail", 32'(ccff_tail), 32'(m_chain[CFG_LEN-1]));
    check("done", 32'(cfg_done), 32'(m_valid));
    check("err",  32'(cfg_err),  32'(m_err));
    check("full", 32'(lut_full_out), 32'(m_full));
    check("hi",   32'(lut_hi_out),   32'(m_hi));
    check("lo",   32'(lut_lo_out),   32'(m_lo));
  endtask

  task automatic cycle(input logic rst, input logic en, input logic head,
                       input logic [K-1:0] inx, input logic ffe);
    reset     = rst;
    cfg_en    = en;
    ccff_head = head;
    in_v      = inx;
    ff_en     = ffe;
    @(posedge clk);
    model_edge(rst, en, head, inx, ffe);
    @(negedge clk);
    check_all();
  endtask

  // Sends v[CFG_LEN-1] first; bits beyond CFG_LEN are random. With rb set,
  // the tail must replay prev in order from the first shift cycle.
  task automatic load(input logic [CFG_LEN-1:0] v, input int n, input bit rb,
                      input logic [CFG_LEN-1:0] prev);
    for (int j = 0; j < n; j++) begin
      logic b;
      b = (j < CFG_LEN) ? v[CFG_LEN-1-j] : 1'($urandom_range(0, 1));
      if (rb && j < CFG_LEN) check("readback", 32'(ccff_tail), 32'(prev[CFG_LEN-1-j]));
      cycle(1'b0, 1'b1, b, K'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic rand_vec(output logic [CFG_LEN-1:0] v);
    for (int i = 0; i < CFG_LEN; i++) v[i] = 1'($urandom_range(0, 1));
  endtask

  logic [CFG_LEN-1:0] v1, v2, v3, vr;

  initial begin
    reset = 1'b1; cfg_en = 1'b0; ccff_head = 1'b0; in_v = '0; ff_en = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("rst_full", 32'(lut_full_out), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_tail", 32'(ccff_tail), 32'd0);

    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    check("uncfg_full", 32'(lut_full_out), 32'd0);

    // tt[63] only, mode 00
    v1 = '0; v1[63] = 1'b1;
    load(v1, CFG_LEN, 1'b0, '0);
    check("load_done_low", 32'(cfg_done), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    check("done_after_load", 32'(cfg_done), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    check("t63_full", 32'(lut_full_out), 32'd1);
    check("t63_hi",   32'(lut_hi_out),   32'h2);
    check("t63_lo",   32'(lut_lo_out),   32'h8);
    cycle(1'b0, 1'b0, 1'b0, 6'h3E, 1'b1);
    check("t62_full", 32'(lut_full_out), 32'd0);
    check("t62_hi",   32'(lut_hi_out),   32'd0);
    check("t62_lo",   32'(lut_lo_out),   32'd0);

    // tt[48] only, mode 11, with readback of v1
    v2 = '0; v2[48] = 1'b1; v2[64] = 1'b1; v2[65] = 1'b1;
    load(v2, CFG_LEN, 1'b1, v1);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    check("m11_full", 32'(lut_full_out), 32'd1);
    check("m11_hi",   32'(lut_hi_out),   32'h2);
    check("m11_lo",   32'(lut_lo_out),   32'h8);

    // ff_en=0 holds outputs while inputs change
    cycle(1'b0, 1'b0, 1'b0, 6'h15, 1'b0);
    check("hold_full", 32'(lut_full_out), 32'd1);

    v3 = '0; v3[48] = 1'b1;
    load(v3, CFG_LEN, 1'b1, v2);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    check("m00_full", 32'(lut_full_out), 32'd0);

    // Wrong-length bursts
    rand_vec(vr);
    load(vr, CFG_LEN - 1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    check("short_err",  32'(cfg_err),  32'd1);
    check("short_done", 32'(cfg_done), 32'd0);
    check("short_full", 32'(lut_full_out), 32'd0);
    rand_vec(vr);
    load(vr, CFG_LEN + 1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    check("long_err", 32'(cfg_err), 32'd1);
    rand_vec(vr);
    load(vr, CFG_LEN + 128, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1);
    check("wrap_err",  32'(cfg_err),  32'd1);
    check("wrap_done", 32'(cfg_done), 32'd0);

    // Reset mid-load
    rand_vec(vr);
    load(vr, 30, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 6'h3F, 1'b1);
    check("midrst_err",  32'(cfg_err),   32'd0);
    check("midrst_tail", 32'(ccff_tail), 32'd0);
    check("midrst_done", 32'(cfg_done),  32'd0);
    rand_vec(vr);
    load(vr, CFG_LEN, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    check("post_rst_done", 32'(cfg_done), 32'd1);

    // Randomised loads and LUT traffic
    for (int it = 0; it < 24; it++) begin
      int n;
      rand_vec(vr);
      n = ($urandom_range(0, 9) < 7) ? CFG_LEN : int'($urandom_range(60, 72));
      load(vr, n, 1'b0, '0);
      for (int c = 0; c < 16; c++) begin
        cycle(1'($urandom_range(0, 59) == 0), 1'b0, 1'b0, K'($urandom),
              1'($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
